// File: rtl/led_blink_bank_pkg.sv
// led_blink_pkg
// Shared definitions for the LED blinker bank:
//   - mode_e       : 2-bit channel mode encoding (OFF / ON / BLINK / BURST)
//   - burst_cnt_w  : width of a counter that must hold 0 .. 2*burst_len
//   - mode_active  : true for modes that run the step accumulator
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  // Counter width able to represent every toggle count of a full burst.
  function automatic int burst_cnt_w(input int burst_len);
    return $clog2(2 * burst_len + 1);
  endfunction

  // BLINK and BURST are the only modes that accumulate and toggle.
  function automatic logic mode_active(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BURST);
  endfunction

endpackage

// File: rtl/led_blink_bank_channel.sv
// blink_channel
// One LED blinker channel: fractional step accumulator with remainder carry,
// toggle generation, burst toggle counter and previous-mode register used
// to detect mode entry.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   sw     in   speed select (1 = STEP_FAST, 0 = STEP_SLOW)
//   mode   in   channel mode (mode_e)
//   sync   in   one-cycle re-phase pulse (affects BLINK/BURST only)
//   led    out  LED drive, registered
//   tick   out  one-cycle pulse in the cycle led toggles, registered
//   done   out  high while a BURST has completed, registered
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int HALF_PERIOD = 50000000,
  parameter int STEP_SLOW   = 2,
  parameter int STEP_FAST   = 15,
  parameter int BURST_LEN   = 3,
  parameter int CNT_W       = 27
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  sw,
  input  mode_e mode,
  input  logic  sync,
  output logic  led,
  output logic  tick,
  output logic  done
);

  localparam int BCW = burst_cnt_w(BURST_LEN);

  // Threshold and steps widened to the CNT_W+1 bit sum width.
  localparam logic [CNT_W:0]   HP_EXT    = (CNT_W + 1)'(HALF_PERIOD);
  localparam logic [CNT_W:0]   STEP_S    = (CNT_W + 1)'(STEP_SLOW);
  localparam logic [CNT_W:0]   STEP_F    = (CNT_W + 1)'(STEP_FAST);
  localparam logic [CNT_W-1:0] ACC_ZERO  = CNT_W'(0);
  localparam logic [BCW-1:0]   BCNT_ZERO = BCW'(0);
  localparam logic [BCW-1:0]   BCNT_ONE  = BCW'(1);
  // Count value held just before the final toggle of a burst.
  localparam logic [BCW-1:0]   BCNT_LAST = BCW'(2 * BURST_LEN - 1);

  logic [CNT_W-1:0] acc_r;
  logic             led_r;
  logic             tick_r;
  logic             done_r;
  logic [BCW-1:0]   bcnt_r;
  mode_e            prev_mode_r;

  logic [CNT_W:0]   step_s;
  logic [CNT_W:0]   sum_s;
  logic             toggle_s;
  logic [CNT_W-1:0] acc_adv_s;
  logic             active_s;
  logic             restart_s;

  logic [CNT_W-1:0] acc_nxt_s;
  logic             led_nxt_s;
  logic             tick_nxt_s;
  logic             done_nxt_s;
  logic [BCW-1:0]   bcnt_nxt_s;

  // Step selection, threshold compare and remainder-carrying advance.
  always_comb begin
    if (sw) begin
      step_s = STEP_F;
    end else begin
      step_s = STEP_S;
    end
    sum_s    = {1'b0, acc_r} + step_s;
    toggle_s = (sum_s >= HP_EXT);
    // The overshoot past the threshold is kept so the average period is exact.
    if (toggle_s) begin
      acc_adv_s = CNT_W'(sum_s - HP_EXT);
    end else begin
      acc_adv_s = CNT_W'(sum_s);
    end
  end

  // Entering BLINK/BURST (including BLINK<->BURST) or SYNC restarts the phase.
  always_comb begin
    active_s  = mode_active(mode);
    restart_s = active_s && (sync || (mode != prev_mode_r));
  end

  // Next-state selection for accumulator, LED, tick, done and burst count.
  always_comb begin
    acc_nxt_s  = acc_r;
    led_nxt_s  = led_r;
    tick_nxt_s = 1'b0;
    done_nxt_s = done_r;
    bcnt_nxt_s = bcnt_r;
    if (restart_s) begin
      acc_nxt_s  = ACC_ZERO;
      led_nxt_s  = 1'b0;
      done_nxt_s = 1'b0;
      bcnt_nxt_s = BCNT_ZERO;
    end else begin
      case (mode)
        MODE_OFF: begin
          acc_nxt_s  = ACC_ZERO;
          led_nxt_s  = 1'b0;
          done_nxt_s = 1'b0;
          bcnt_nxt_s = BCNT_ZERO;
        end
        MODE_ON: begin
          acc_nxt_s  = ACC_ZERO;
          led_nxt_s  = 1'b1;
          done_nxt_s = 1'b0;
          bcnt_nxt_s = BCNT_ZERO;
        end
        MODE_BLINK: begin
          acc_nxt_s  = acc_adv_s;
          done_nxt_s = 1'b0;
          bcnt_nxt_s = BCNT_ZERO;
          if (toggle_s) begin
            led_nxt_s  = ~led_r;
            tick_nxt_s = 1'b1;
          end else begin
            led_nxt_s  = led_r;
          end
        end
        MODE_BURST: begin
          if (done_r) begin
            // Finished burst parks with the LED dark until re-entry.
            acc_nxt_s = ACC_ZERO;
            led_nxt_s = 1'b0;
          end else begin
            acc_nxt_s = acc_adv_s;
            if (toggle_s) begin
              led_nxt_s  = ~led_r;
              tick_nxt_s = 1'b1;
              bcnt_nxt_s = bcnt_r + BCNT_ONE;
              // Final toggle: DONE rises together with this TICK.
              if (bcnt_r == BCNT_LAST) begin
                done_nxt_s = 1'b1;
                led_nxt_s  = 1'b0;
                acc_nxt_s  = ACC_ZERO;
              end else begin
                done_nxt_s = 1'b0;
              end
            end else begin
              led_nxt_s = led_r;
            end
          end
        end
        default: begin
          acc_nxt_s  = ACC_ZERO;
          led_nxt_s  = 1'b0;
          done_nxt_s = 1'b0;
          bcnt_nxt_s = BCNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= ACC_ZERO;
      led_r       <= 1'b0;
      tick_r      <= 1'b0;
      done_r      <= 1'b0;
      bcnt_r      <= BCNT_ZERO;
      prev_mode_r <= MODE_OFF;
    end else begin
      acc_r       <= acc_nxt_s;
      led_r       <= led_nxt_s;
      tick_r      <= tick_nxt_s;
      done_r      <= done_nxt_s;
      bcnt_r      <= bcnt_nxt_s;
      prev_mode_r <= mode;
    end
  end

  assign led  = led_r;
  assign tick = tick_r;
  assign done = done_r;

endmodule

// File: rtl/led_blink_bank.sv
// led_blink_bank
// Bank of NCH independent LED blinkers sharing one clock, reset and SYNC.
// Ports:
//   CLOCK_50  in   system clock
//   RESET     in   synchronous, active-high reset
//   SW        in   [NCH]   per-channel speed select (1 = fast)
//   MODE      in   [2*NCH] channel i mode in MODE[2i+1:2i]
//   SYNC      in   one-cycle pulse re-phasing all BLINK/BURST channels
//   LEDR      out  [NCH]   LED drive, registered
//   TICK      out  [NCH]   toggle pulse, registered
//   DONE      out  [NCH]   burst-complete flag, registered
module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int HALF_PERIOD = 50000000,
  parameter int STEP_SLOW   = 2,
  parameter int STEP_FAST   = 15,
  parameter int BURST_LEN   = 3,
  parameter int CNT_W       = 27
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [NCH-1:0]   SW,
  input  logic [2*NCH-1:0] MODE,
  input  logic             SYNC,
  output logic [NCH-1:0]   LEDR,
  output logic [NCH-1:0]   TICK,
  output logic [NCH-1:0]   DONE
);

  for (genvar i = 0; i < NCH; i++) begin : gen_ch
    mode_e ch_mode;

    assign ch_mode = mode_e'(MODE[2*i +: 2]);

    blink_channel #(
      .HALF_PERIOD (HALF_PERIOD),
      .STEP_SLOW   (STEP_SLOW),
      .STEP_FAST   (STEP_FAST),
      .BURST_LEN   (BURST_LEN),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk   (CLOCK_50),
      .reset (RESET),
      .sw    (SW[i]),
      .mode  (ch_mode),
      .sync  (SYNC),
      .led   (LEDR[i]),
      .tick  (TICK[i]),
      .done  (DONE[i])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb_led_blink_bank
// Directed scenarios plus randomized stimulus, every cycle compared against a
// behavioural model that tracks each channel as integer phase, toggle count
// and LED level.
module tb_led_blink_bank;

  localparam int NCH = 4;
  localparam int HP  = 10;
  localparam int SS  = 2;
  localparam int SF  = 3;
  localparam int BL  = 2;
  localparam int CW  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   sw;
  logic [2*NCH-1:0] mode;
  logic             sync;
  logic [NCH-1:0]   ledr;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   done;

  led_blink_bank #(
    .NCH(NCH), .HALF_PERIOD(HP), .STEP_SLOW(SS), .STEP_FAST(SF),
    .BURST_LEN(BL), .CNT_W(CW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (reset),
    .SW       (sw),
    .MODE     (mode),
    .SYNC     (sync),
    .LEDR     (ledr),
    .TICK     (tick),
    .DONE     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int             m_acc  [NCH];
  int             m_tog  [NCH];
  logic [1:0]     m_prev [NCH];
  logic [NCH-1:0] m_led;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Apply one clock edge worth of channel rules to the model.
  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      logic [1:0] md;
      int         s;
      bit         running;
      md      = mode[2*i +: 2];
      running = (md == 2'b10) || (md == 2'b11);
      s       = sw[i] ? SF : SS;
      m_tick[i] = 1'b0;
      if (reset) begin
        m_acc[i] = 0; m_tog[i] = 0; m_led[i] = 1'b0; m_done[i] = 1'b0; m_prev[i] = 2'b00;
      end else begin
        if (running && (sync || md != m_prev[i])) begin
          m_acc[i] = 0; m_tog[i] = 0; m_led[i] = 1'b0; m_done[i] = 1'b0;
        end else if (!running) begin
          m_acc[i] = 0; m_tog[i] = 0; m_done[i] = 1'b0;
          m_led[i] = (md == 2'b01);
        end else if (md == 2'b11 && m_done[i]) begin
          m_acc[i] = 0; m_led[i] = 1'b0;
        end else begin
          m_acc[i] = m_acc[i] + s;
          if (m_acc[i] >= HP) begin
            m_acc[i]  = m_acc[i] - HP;
            m_led[i]  = ~m_led[i];
            m_tick[i] = 1'b1;
            m_tog[i]++;
            if (md == 2'b11 && m_tog[i] == 2 * BL) begin
              m_done[i] = 1'b1;
              m_acc[i]  = 0;
            end
          end
        end
        m_prev[i] = md;
      end
    end
  endtask

  // One clock: update model at the edge, compare all outputs just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_eq("ledr", 32'(ledr), 32'(m_led));
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("done", 32'(done), 32'(m_done));
  endtask

  initial begin
    int q0[$];
    int q1[$];
    int q2[$];
    int done2_at;
    int t0;
    int t1;
    int k;

    reset = 1'b1; sw = 4'b0000; mode = 8'h00; sync = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_ledr", 32'(ledr), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    // ch0 BLINK slow, ch1 BLINK fast, ch2 BURST slow, ch3 ON; entry at release
    mode = {2'b01, 2'b11, 2'b10, 2'b10};
    sw   = 4'b0010;
    reset = 1'b0;
    done2_at = -1;
    for (int c = 0; c < 75; c++) begin
      step();
      if (tick[0]) q0.push_back(c);
      if (tick[1]) q1.push_back(c);
      if (tick[2]) q2.push_back(c);
      if (done[2] && done2_at < 0) done2_at = c;
    end
    check_eq("ch0_first_tick", q0[0], 32'd5);
    check_eq("ch0_second_tick", q0[1], 32'd10);
    check_eq("ch1_tick_a", q1[0], 32'd4);
    check_eq("ch1_tick_b", q1[1], 32'd7);
    check_eq("ch1_tick_c", q1[2], 32'd10);
    check_eq("ch1_tick_d", q1[3], 32'd14);
    check_eq("ch2_burst_ticks", q2.size(), 32'd4);
    check_eq("ch2_last_tick", q2[3], 32'd20);
    check_eq("ch2_done_at", done2_at, 32'd20);
    check_eq("ch2_led_parked", 32'(ledr[2]), 32'd0);
    check_eq("ch3_on", 32'(ledr[3]), 32'd1);

    // ch3 OFF, then SYNC mid-period
    mode[7:6] = 2'b00;
    step();
    check_eq("ch3_off", 32'(ledr[3]), 32'd0);
    repeat (2) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_eq("sync_led01", 32'(ledr[1:0]), 32'd0);
    check_eq("sync_done2", 32'(done[2]), 32'd0);
    t0 = 0; t1 = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (tick[0] && t0 == 0) t0 = c;
      if (tick[1] && t1 == 0) t1 = c;
    end
    check_eq("sync_ch0_next", t0, 32'd5);
    check_eq("sync_ch1_next", t1, 32'd4);

    // SW flip with acc0 = 6
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (3) step();
    check_eq("acc0_six", 32'(dut.gen_ch[0].u_ch.acc_r), 32'd6);
    sw[0] = 1'b1;
    step();
    check_eq("acc0_nine", 32'(dut.gen_ch[0].u_ch.acc_r), 32'd9);
    check_eq("flip_no_tick", 32'(tick[0]), 32'd0);
    step();
    check_eq("flip_tick", 32'(tick[0]), 32'd1);
    check_eq("acc0_rem", 32'(dut.gen_ch[0].u_ch.acc_r), 32'd2);
    sw[0] = 1'b0;

    // Re-enter BURST on ch2 via OFF, then reset while its LED is lit
    mode[5:4] = 2'b00;
    step();
    mode[5:4] = 2'b11;
    step();
    repeat (5) step();
    check_eq("burst_led_on", 32'(ledr[2]), 32'd1);
    check_eq("burst_first_tick", 32'(tick[2]), 32'd1);
    reset = 1'b1;
    step();
    check_eq("midrst_ledr", 32'(ledr), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    step();
    repeat (4) step();
    check_eq("rerun_no_tick", 32'(tick[2]), 32'd0);
    step();
    check_eq("rerun_tick", 32'(tick[2]), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, NCH - 1);
        mode[2*k +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NCH - 1);
        sw[k] = ~sw[k];
      end
      sync  = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
